// File: rtl/ram2reg_if.sv
// RAM-side bus of ram2reg: read-only access to a synchronous 32-bit RAM.
// ram2reg drives it through the master modport; the RAM sits on the slave modport.
interface ram2reg_if;
    logic        ram_clk;
    logic        ram_rst;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_rd_data;

    modport master (
        output ram_clk,
        output ram_rst,
        output ram_en,
        output ram_addr,
        output ram_we,
        output ram_wr_data,
        input  ram_rd_data
    );

    modport slave (
        input  ram_clk,
        input  ram_rst,
        input  ram_en,
        input  ram_addr,
        input  ram_we,
        input  ram_wr_data,
        output ram_rd_data
    );
endinterface

// File: rtl/ram2reg.sv
// ram2reg: on a rising edge of rd_en_i, copies WORDS consecutive words from RAM into a
// 32-entry register file. Define RAM2REG_CHECKSUM_EN to add the XOR checksum output csum_o.
module ram2reg #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WORDS     = 32,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    ram2reg_if.master   ram,
    input  logic        rd_en_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic [4:0]  reg_addr_i,
    output logic [31:0] reg_data_o
`ifdef RAM2REG_CHECKSUM_EN
    ,
    output logic [31:0] csum_o
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [4:0] LAST_IDX   = 5'(WORDS - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    logic [1:0]  state;
    logic [4:0]  idx;
    logic [1:0]  drain_cnt;
    logic        rd_en_d;
    logic        start;

    logic        vld_p0, vld_p1, vld_p2;
    logic [4:0]  idx_p0, idx_p1, idx_p2;
    logic        cap_vld;
    logic [4:0]  cap_idx;

    logic [31:0] regs [32];

    // rd_en_d resets high so a level held through reset is not seen as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_d <= 1'b1;
        end else begin
            rd_en_d <= rd_en_i;
        end
    end

    assign start = rd_en_i & ~rd_en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        idx   <= '0;
                    end
                end
                READ: begin
                    if (idx == LAST_IDX) begin
                        state     <= DRAIN;
                        idx       <= '0;
                        drain_cnt <= '0;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage p0..p2: issued-read tracking, one stage per cycle of RAM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= (state == READ);
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        idx_p0 <= idx;
        idx_p1 <= idx_p0;
        idx_p2 <= idx_p1;
    end

    always_comb begin
        cap_vld = vld_p0;
        cap_idx = idx_p0;
        if (RD_LAT == 2) begin
            cap_vld = vld_p1;
            cap_idx = idx_p1;
        end else if (RD_LAT >= 3) begin
            cap_vld = vld_p2;
            cap_idx = idx_p2;
        end
    end

    // Capture: only indices below WORDS are ever issued, so higher entries keep their value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (cap_vld) begin
            regs[cap_idx] <= ram.ram_rd_data;
        end
    end

    assign reg_data_o = regs[reg_addr_i];

`ifdef RAM2REG_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (cap_vld) begin
            csum <= csum ^ ram.ram_rd_data;
        end
    end

    assign csum_o = csum;
`endif

    assign busy_o          = (state != IDLE);
    assign done_o          = (state == DONE);

    assign ram.ram_clk     = clk;
    assign ram.ram_rst     = rst;
    assign ram.ram_en      = (state == READ);
    assign ram.ram_addr    = (state == READ) ? BASE_ADDR + {25'd0, idx, 2'b00} : BASE_ADDR;
    assign ram.ram_we      = 4'b0000;
    assign ram.ram_wr_data = 32'h0;

endmodule

// File: tb/tb_ram2reg.sv
// Bench for ram2reg: a default instance and a WORDS=8/RD_LAT=2/BASE_ADDR=0x100 instance,
// driven from a scenario table and random runs, checked against a load-level model.
`timescale 1ns/1ps
module tb_ram2reg;

    localparam int RUN_CYCLES = 110;

    typedef struct {
        int d;          // 0: default instance, 1: small instance
        int mode;       // 0: word i = 3i, 1: random, 2: {1,2,4,8,0...}
        int hold;       // rd_en_i high for cycles [0, hold)
        int reedge;     // >0: rd_en_i high again for cycles [reedge, reedge+5)
        int rst_at;     // cycle of a one-cycle rst pulse, -1 none
        int probe_idx;  // register watched during the load
        int probe_cyc;  // cycle the watched register is checked, -1 none
        int exp_done;   // cycle of the done_o pulse, -1 none
    } scen_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rd_en_a, rd_en_b;
    logic [4:0]  reg_addr_a, reg_addr_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [31:0] reg_data_a, reg_data_b;
`ifdef RAM2REG_CHECKSUM_EN
    logic [31:0] csum_a, csum_b;
`endif

    ram2reg_if bus_a ();
    ram2reg_if bus_b ();

    ram2reg #(.BASE_ADDR(32'h0), .WORDS(32), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst_a), .ram(bus_a), .rd_en_i(rd_en_a), .busy_o(busy_a),
        .done_o(done_a), .reg_addr_i(reg_addr_a), .reg_data_o(reg_data_a)
`ifdef RAM2REG_CHECKSUM_EN
        , .csum_o(csum_a)
`endif
    );

    ram2reg #(.BASE_ADDR(32'h100), .WORDS(8), .RD_LAT(2)) u_b (
        .clk(clk), .rst(rst_b), .ram(bus_b), .rd_en_i(rd_en_b), .busy_o(busy_b),
        .done_o(done_b), .reg_addr_i(reg_addr_b), .reg_data_o(reg_data_b)
`ifdef RAM2REG_CHECKSUM_EN
        , .csum_o(csum_b)
`endif
    );

    // RAM models: registered read, plus one extra register stage for the latency-2 RAM
    logic [31:0] mem [2][64];
    logic [31:0] q1_a, q1_b, q2_b;

    always @(posedge clk) begin
        if (bus_a.ram_en) q1_a <= mem[0][bus_a.ram_addr[7:2]];
    end

    always @(posedge clk) begin
        if (bus_b.ram_en) q1_b <= mem[1][6'((bus_b.ram_addr - 32'h100) >> 2)];
        q2_b <= q1_b;
    end

    assign bus_a.ram_rd_data = q1_a;
    assign bus_b.ram_rd_data = q2_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_regs [2][32];
    scen_t       tbl [8];

    function automatic int words_of(input int d); return (d == 0) ? 32 : 8; endfunction
    function automatic int lat_of(input int d); return (d == 0) ? 1 : 2; endfunction
    function automatic logic [31:0] base_of(input int d); return (d == 0) ? 32'h0 : 32'h100; endfunction

    function automatic logic get_busy(input int d); return (d == 0) ? busy_a : busy_b; endfunction
    function automatic logic get_done(input int d); return (d == 0) ? done_a : done_b; endfunction
    function automatic logic get_en(input int d); return (d == 0) ? bus_a.ram_en : bus_b.ram_en; endfunction
    function automatic logic get_rrst(input int d); return (d == 0) ? bus_a.ram_rst : bus_b.ram_rst; endfunction
    function automatic logic get_rclk(input int d); return (d == 0) ? bus_a.ram_clk : bus_b.ram_clk; endfunction
    function automatic logic [3:0] get_we(input int d); return (d == 0) ? bus_a.ram_we : bus_b.ram_we; endfunction
    function automatic logic [31:0] get_addr(input int d); return (d == 0) ? bus_a.ram_addr : bus_b.ram_addr; endfunction
    function automatic logic [31:0] get_wdat(input int d); return (d == 0) ? bus_a.ram_wr_data : bus_b.ram_wr_data; endfunction
    function automatic logic [31:0] get_rdata(input int d); return (d == 0) ? reg_data_a : reg_data_b; endfunction
`ifdef RAM2REG_CHECKSUM_EN
    function automatic logic [31:0] get_csum(input int d); return (d == 0) ? csum_a : csum_b; endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic rd, input logic rs, input logic [4:0] ra);
        if (d == 0) begin
            rd_en_a = rd; rst_a = rs; reg_addr_a = ra;
        end else begin
            rd_en_b = rd; rst_b = rs; reg_addr_b = ra;
        end
    endtask

    task automatic fill_mem(input int d, input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       mem[d][i] = 32'(3 * i);
                1:       mem[d][i] = $urandom;
                default: mem[d][i] = (i < 4) ? (32'h1 << i) : 32'h0;
            endcase
        end
    endtask

    task automatic run_scen(input int k, input scen_t s);
        int          w, lat, pulses, first_done, seq_err, regs_err, bad_i;
        logic [31:0] base, exp_addr, exp_val, csum_exp;
        logic [31:0] prev [32];
        logic        exp_en, exp_busy, alive, rd;
        w = words_of(s.d);
        lat = lat_of(s.d);
        base = base_of(s.d);
        fill_mem(s.d, s.mode);
        for (int i = 0; i < 32; i++) prev[i] = exp_regs[s.d][i];
        csum_exp = '0;
        for (int i = 0; i < w; i++) csum_exp ^= mem[s.d][i];
        pulses = 0; first_done = -1; seq_err = 0;

        repeat (2) begin
            @(posedge clk); #1;
            drive(s.d, 1'b0, 1'b0, 5'(s.probe_idx));
        end

        for (int c = 0; c < RUN_CYCLES; c++) begin
            @(posedge clk); #1;
            rd = (c < s.hold) || (s.reedge > 0 && c >= s.reedge && c < s.reedge + 5);
            drive(s.d, rd, (c == s.rst_at), 5'(s.probe_idx));
            @(negedge clk);
            alive    = (s.rst_at < 0) || (c <= s.rst_at);
            exp_en   = (c >= 1) && (c <= w) && alive;
            exp_busy = (c >= 1) && (c <= w + lat + 1) && alive;
            exp_addr = exp_en ? base + 32'(4 * (c - 1)) : base;
            if (get_en(s.d) !== exp_en || get_addr(s.d) !== exp_addr) seq_err++;
            if (get_we(s.d) !== 4'h0 || get_wdat(s.d) !== 32'h0 || get_rclk(s.d) !== 1'b0) seq_err++;
            if (get_rrst(s.d) !== (c == s.rst_at)) seq_err++;
            if (get_busy(s.d) !== exp_busy) seq_err++;
            if (get_done(s.d) === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = c;
`ifdef RAM2REG_CHECKSUM_EN
                check($sformatf("s%0d_csum", k), get_csum(s.d), csum_exp);
`endif
            end
            if (c == s.probe_cyc) begin
                exp_val = (s.probe_idx < w && s.probe_idx <= c - 2 - lat) ?
                          mem[s.d][s.probe_idx] : prev[s.probe_idx];
                check($sformatf("s%0d_probe_reg%0d_c%0d", k, s.probe_idx, c), get_rdata(s.d), exp_val);
            end
        end

        check($sformatf("s%0d_done_cycle", k), 32'(first_done), 32'(s.exp_done));
        check($sformatf("s%0d_done_pulses", k), 32'(pulses), (s.exp_done >= 0) ? 32'd1 : 32'd0);
        check($sformatf("s%0d_ram_busy_seq_errors", k), 32'(seq_err), 32'd0);

        for (int i = 0; i < 32; i++) begin
            if (s.rst_at >= 0) exp_regs[s.d][i] = '0;
            else if (i < w) exp_regs[s.d][i] = mem[s.d][i];
        end
        regs_err = 0; bad_i = -1;
        for (int i = 0; i < 32; i++) begin
            drive(s.d, 1'b0, 1'b0, 5'(i));
            #1;
            if (get_rdata(s.d) !== exp_regs[s.d][i]) begin
                regs_err++;
                if (bad_i < 0) bad_i = i;
            end
        end
        check($sformatf("s%0d_reg_errors_first_at_%0d", k, bad_i), 32'(regs_err), 32'd0);
    endtask

    initial begin
        // d, mode, hold, reedge, rst_at, probe_idx, probe_cyc, exp_done
        tbl[0] = '{0, 0,   3,  0, -1,  5, 10, 34};
        tbl[1] = '{0, 1, 100,  0, -1, 20, 10, 34};
        tbl[2] = '{0, 1,   3, 10, -1,  0,  5, 34};
        tbl[3] = '{0, 1,   3,  0, 15,  2,  8, -1};
        tbl[4] = '{0, 0,   3,  0, -1, 31, 34, 34};
        tbl[5] = '{0, 2,   3,  0, -1,  3, 20, 34};
        tbl[6] = '{1, 0,   3,  0, -1,  3,  9, 11};
        tbl[7] = '{1, 1,   3,  6, -1,  7, 11, 11};

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) exp_regs[d][i] = '0;
        for (int d = 0; d < 2; d++) fill_mem(d, 0);

        // Reset with rd_en_i held high, which must not start a load on release
        rst_a = 1'b1; rst_b = 1'b1; rd_en_a = 1'b1; rd_en_b = 1'b1;
        reg_addr_a = 5'd0; reg_addr_b = 5'd31;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_busy_%0d", d), 32'(get_busy(d)), 32'd0);
            check($sformatf("rst_done_%0d", d), 32'(get_done(d)), 32'd0);
            check($sformatf("rst_ram_en_%0d", d), 32'(get_en(d)), 32'd0);
            check($sformatf("rst_ram_addr_%0d", d), get_addr(d), base_of(d));
            check($sformatf("rst_reg_%0d", d), get_rdata(d), 32'd0);
`ifdef RAM2REG_CHECKSUM_EN
            check($sformatf("rst_csum_%0d", d), get_csum(d), 32'd0);
`endif
        end
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("held_high_no_start_busy_%0d_c%0d", d, c), 32'(get_busy(d)), 32'd0);
                check($sformatf("held_high_no_start_en_%0d_c%0d", d, c), 32'(get_en(d)), 32'd0);
            end
            @(posedge clk); #1;
        end
        rd_en_a = 1'b0; rd_en_b = 1'b0;

        for (int k = 0; k < 8; k++) run_scen(k, tbl[k]);

        for (int r = 0; r < 6; r++) begin
            scen_t s;
            int    ed;
            s.d = int'($urandom_range(0, 1));
            s.mode = 1;
            s.hold = int'($urandom_range(1, 60));
            ed = words_of(s.d) + lat_of(s.d) + 1;
            s.rst_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 45)) : -1;
            s.reedge = 0;
            if (s.rst_at < 0 && s.hold + 2 < ed) s.reedge = int'($urandom_range(s.hold + 2, ed - 1));
            s.probe_idx = int'($urandom_range(0, 31));
            s.probe_cyc = int'($urandom_range(1, 40));
            if (s.rst_at >= 0 && s.probe_cyc > s.rst_at) s.probe_cyc = -1;
            s.exp_done = (s.rst_at < 0 || s.rst_at >= ed) ? ed : -1;
            run_scen(100 + r, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
